// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps per op.
// Optional macro MULDIV_FAST_SPECIAL_EN lets div-by-zero, signed overflow and zero-operand multiplies bypass CALC.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            we,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result,
    output logic [1:0]      fsm_state
);

    // Handshake: start is sampled only while idle; busy stays high from the accepting
    // edge through the single done cycle; a start seen while busy is dropped, not queued.

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST_STEP = 6'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [5:0]      cnt;
    logic [2:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] a_orig_q;
    logic [XLEN-1:0] b_mag_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic            neg_q;
    logic            neg_r;
    logic            dz_q;
    logic            ovf_q;

    // Operand decode at acceptance
    logic            a_signed_in;
    logic            b_signed_in;
    logic            a_neg_in;
    logic            b_neg_in;
    logic [XLEN-1:0] a_mag_in;
    logic [XLEN-1:0] b_mag_in;
    logic            dz_in;
    logic            ovf_in;
    logic            fast_take;

    // One iteration of the datapath
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_qbit;
    logic [XLEN-1:0] hi_next;
    logic [XLEN-1:0] lo_next;
    logic            last_iter;
    logic [XLEN-1:0] calc_result;

    // Turns magnitudes plus sign flags into the architectural result.
    // For multiplies {hi,lo} is the unsigned product; for divides lo is the quotient, hi the remainder.
    function automatic logic [XLEN-1:0] finalize(
        input logic [2:0]      f_op,
        input logic            f_neg_q,
        input logic            f_neg_r,
        input logic            f_dz,
        input logic            f_ovf,
        input logic [XLEN-1:0] f_a,
        input logic [XLEN-1:0] f_hi,
        input logic [XLEN-1:0] f_lo
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   res;
        prod = {f_hi, f_lo};
        if (f_neg_q) begin
            prod = -prod;
        end
        res = '0;
        case (f_op)
            OP_MUL:                       res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
            OP_DIV: begin
                if (f_dz)         res = '1;
                else if (f_ovf)   res = MIN_NEG;
                else if (f_neg_q) res = -f_lo;
                else              res = f_lo;
            end
            OP_DIVU:              res = f_dz ? '1 : f_lo;
            OP_REM: begin
                if (f_dz)         res = f_a;
                else if (f_ovf)   res = '0;
                else if (f_neg_r) res = -f_hi;
                else              res = f_hi;
            end
            OP_REMU:              res = f_dz ? f_a : f_hi;
            default:              res = '0;
        endcase
        return res;
    endfunction

    assign a_signed_in = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed_in = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign a_neg_in    = a_signed_in && rs1_data[XLEN-1];
    assign b_neg_in    = b_signed_in && rs2_data[XLEN-1];
    assign a_mag_in    = a_neg_in ? -rs1_data : rs1_data;
    assign b_mag_in    = b_neg_in ? -rs2_data : rs2_data;
    assign dz_in       = op[2] && (rs2_data == '0);
    assign ovf_in      = ((op == OP_DIV) || (op == OP_REM)) && (rs1_data == MIN_NEG) && (rs2_data == '1);

`ifdef MULDIV_FAST_SPECIAL_EN
    logic            mz_in;
    logic [XLEN-1:0] fast_result;
    assign mz_in       = !op[2] && ((rs1_data == '0) || (rs2_data == '0));
    assign fast_take   = dz_in || ovf_in || mz_in;
    // A zero multiply has a zero product, so the accumulator inputs are simply zero.
    assign fast_result = finalize(op, a_neg_in ^ b_neg_in, a_neg_in, dz_in, ovf_in,
                                  rs1_data, '0, '0);
`else
    assign fast_take   = 1'b0;
`endif

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift[XLEN-1:0] - b_mag_q;
        div_qbit  = (div_shift >= {1'b0, b_mag_q});
        hi_next   = hi_q;
        lo_next   = lo_q;
        if (op_q[2]) begin
            // Restoring step: the remainder stays below the divisor, so XLEN bits hold it.
            hi_next = div_qbit ? div_diff : div_shift[XLEN-1:0];
            lo_next = {lo_q[XLEN-2:0], div_qbit};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    assign last_iter   = (state == CALC) && (cnt == LAST_STEP);
    assign calc_result = finalize(op_q, neg_q, neg_r, dz_q, ovf_q, a_orig_q, hi_next, lo_next);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = fast_take ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= OP_MUL;
            rd_q     <= '0;
            a_orig_q <= '0;
            b_mag_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            rd_out   <= '0;
            result   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        rd_q     <= rd_in;
                        a_orig_q <= rs1_data;
                        b_mag_q  <= b_mag_in;
                        hi_q     <= '0;
                        lo_q     <= a_mag_in;
                        neg_q    <= a_neg_in ^ b_neg_in;
                        neg_r    <= a_neg_in;
                        dz_q     <= dz_in;
                        ovf_q    <= ovf_in;
                        cnt      <= '0;
`ifdef MULDIV_FAST_SPECIAL_EN
                        if (fast_take) begin
                            result <= fast_result;
                            rd_out <= rd_in;
                        end
`endif
                    end
                end
                CALC: begin
                    hi_q <= hi_next;
                    lo_q <= lo_next;
                    cnt  <= cnt + 6'd1;
                    // Output registers change only as DONE is entered.
                    if (last_iter) begin
                        result <= calc_result;
                        rd_out <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign we        = done && (rd_out != 5'd0);
    assign fsm_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: fixed vector table, hand-written handshake/reset sequences,
// then randomized ops checked against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        done;
    logic        we;
    logic [4:0]  rd_out;
    logic [31:0] result;
    logic [1:0]  fsm_state;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .we        (we),
        .rd_out    (rd_out),
        .result    (result),
        .fsm_state (fsm_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, expv);
        end
    endtask

    // Reference model: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        int              ia;
        int              ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        p  = 64'd0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

`ifdef MULDIV_FAST_SPECIAL_EN
    function automatic logic is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2])
            return (b == 32'd0) || (((o == 3'd4) || (o == 3'd6)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 32'd0) || (b == 32'd0);
    endfunction
`endif

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Driver: called just after a rising edge with the unit idle; returns likewise, unit idle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input string name);
        int   lat;
        int   exp_lat;
        logic got;
        exp_lat = 33;
`ifdef MULDIV_FAST_SPECIAL_EN
        if (is_special(o, a, b)) exp_lat = 1;
`endif
        op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "/busy_on_accept"}, 32'(busy), 32'd1);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 60 && !got; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (done) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk({name, "/done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({name, "/latency"}, 32'(lat), 32'(exp_lat));
            chk({name, "/result"}, result, exp_res);
            chk({name, "/rd_out"}, 32'(rd_out), 32'(rd));
            chk({name, "/we"}, 32'(we), 32'(rd != 5'd0));
            @(posedge clk); #1;
            chk({name, "/busy_after"}, 32'(busy), 32'd0);
            chk({name, "/done_after"}, 32'(done), 32'd0);
            chk({name, "/result_hold"}, result, exp_res);
        end
    endtask

    initial begin
        int          n_done;
        int          first_c;
        logic [31:0] got_res;
        logic [4:0]  got_rd;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;

        vecs[0]  = '{3'd0, 32'd7,          32'd8,          5'd5,  32'd56};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000,  5'd1,  32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,          5'd7,  32'd14};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,          5'd8,  32'd2};
        vecs[8]  = '{3'd5, 32'd100,        32'd0,          5'd9,  32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd100,        32'd0,          5'd10, 32'd100};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0};
        vecs[12] = '{3'd0, 32'd3,          32'd5,          5'd0,  32'd15};
        vecs[13] = '{3'd4, 32'hFFFF_FFF9,  32'd0,          5'd13, 32'hFFFF_FFFF};
        vecs[14] = '{3'd6, 32'hFFFF_FFF9,  32'd0,          5'd31, 32'hFFFF_FFF9};
        vecs[15] = '{3'd0, 32'd0,          32'd12345,      5'd14, 32'd0};

        // Reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset/busy",   32'(busy),   32'd0);
        chk("reset/done",   32'(done),   32'd0);
        chk("reset/we",     32'(we),     32'd0);
        chk("reset/rd_out", 32'(rd_out), 32'd0);
        chk("reset/result", result,      32'd0);

        // Fixed vectors, issued back to back
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // A second start during CALC must be dropped
        op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; first_c = 0; got_res = '0; got_rd = '0;
        for (int c = 1; c <= 80; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (first_c == 0) begin
                    first_c = c;
                    got_res = result;
                    got_rd  = rd_out;
                end
            end
            if (c == 5) begin
                op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd3; rd_in = 5'd9; start = 1'b1;
            end
        end
        chk("restart/done_count", 32'(n_done),  32'd1);
        chk("restart/latency",    32'(first_c), 32'd33);
        chk("restart/result",     got_res,      32'd14);
        chk("restart/rd_out",     32'(got_rd),  32'd3);

        // Reset in the middle of an op
        op = 3'd1; rs1_data = 32'h1234_5678; rs2_data = 32'h9ABC_DEF0; rd_in = 5'd17; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst/busy",   32'(busy),   32'd0);
        chk("midrst/done",   32'(done),   32'd0);
        chk("midrst/we",     32'(we),     32'd0);
        chk("midrst/rd_out", 32'(rd_out), 32'd0);
        chk("midrst/result", result,      32'd0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("midrst/no_done", 32'(n_done), 32'd0);
        run_op(3'd0, 32'd7, 32'd8, 5'd5, 32'd56, "after_rst");

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            o  = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            exp_q.push_back(ref_model(o, a, b));
            run_op(o, a, b, rd, exp_q.pop_front(), $sformatf("rand%0d_op%0d", i, o));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
